uart_rx: RTL
============

// Module: uart_rx
// PURPOSE
//  - 8-bit UART receiver, LSB first, 1 stop bit; receive-side counterpart of the test_tx transmitter.
//  - Shares the same baud_sel table, so the two blocks loop back directly.
//  - Samples serial line rx at 16x oversampling and delivers each byte with a one-cycle rx_valid strobe.
//  - Sits between the pad (async rx) and the byte-consuming logic in the clk domain.
// PARAMETERS
//  CLK_HZ      50_000_000  system clock frequency; the baud divisors are derived from it
//  OVERSAMPLE  16          ticks per bit; must be even and >= 8
// PORTS
//  clk        in   1  system clock, 50 MHz
//  rst        in   1  asynchronous, active-high reset
//  baud_sel   in   3  0:9600 1:19200 2:38400 3:57600 4:115200 5:230400 6:460800 7:921600
//  rx         in   1  serial input, async to clk, idle high
//  rx_data    out  8  last received byte; held until the next good frame
//  rx_valid   out  1  1-cycle strobe: rx_data updated
//  frame_err  out  1  1-cycle strobe: stop bit sampled low
//  parity_err out  1  1-cycle strobe: parity mismatch (UART_RX_PARITY_EN only, else tied 0)
//  busy       out  1  high from start-bit detect until the frame ends (IDLE / WAIT_IDLE = 0)
// BEHAVIOUR
//  - Reset: every output 0; state IDLE; both synchroniser flops 1; tick counter 0.
//  - rx passes through a 2-flop synchroniser, then an edge register (rx_s, rx_d).
//  - Divisor DIV = round(CLK_HZ / (baud * OVERSAMPLE)); baud from table[baud_sel].
//    At 50 MHz: 326, 163, 81, 54, 27, 14, 7, 3.
//  - baud_sel is latched on start detect. Changes mid-frame take effect on the next frame.
//  - Tick generator counts 0..DIV-1 and pulses tick at DIV-1. It restarts at 0 on start detect.
//  - FSM states: IDLE, START, DATA, PARITY (macro only), STOP, WAIT_IDLE.
//  - IDLE -> START: on rx_d=1, rx_s=0 (falling edge); busy=1.
//  - START: after OVERSAMPLE/2 ticks, sample rx_s.
//    rx_s=0: go to DATA, bit index 0.
//    rx_s=1: glitch; return to IDLE with no strobe.
//  - DATA: every OVERSAMPLE ticks, sample rx_s into shift reg bit[idx].
//    After bit 7: go to PARITY (macro) or STOP.
//  - STOP: after OVERSAMPLE ticks, sample.
//    rx_s=1: next cycle rx_data<=shift, rx_valid=1 (with parity_err if flagged), back to IDLE.
//    rx_s=0: next cycle frame_err=1, rx_data unchanged, rx_valid=0, go to WAIT_IDLE.
//  - WAIT_IDLE: stays until rx_s=1 (break/line-low handling), then IDLE.
//  - Strobes never overlap across frames; there is no consumer handshake, so a missed byte is overwritten.
//  - Back-to-back frames: IDLE re-arms in the cycle after the stop sample, so a start edge half a bit later is caught.
//  - Latency: rx_valid occurs 2 (sync) + 1 (edge) + ~9.5 bit-times after the start-bit falling edge at the pin.
//  - rst asserted mid-frame: immediate return to reset values; the partial byte is discarded.
// CONFIGURATION
//  - UART_RX_PARITY_EN defined:
//    - PARITY state samples a 9th bit, even parity over data+parity.
//    - On mismatch, parity_err pulses together with rx_valid; the byte is still delivered.
//  - Undefined: no PARITY state; parity_err constant 0; frame is 10 bits.
// STRUCTURE
//  - Package uart_pkg holds the shared definitions:
//    - the baud table BAUD_RATE[0:7] and the divisor function div_for(clk_hz, sel, os);
//    - the rx state enum and DATA_BITS=8;
//    - the same table is shared with test_tx.
//  - Sub-module uart_baud_tick(clk, rst, div, restart, tick): reusable by the transmitter side.
//  - uart_rx holds the synchroniser, FSM, bit/tick counters and shift reg.
// TESTING (50 MHz clk, 20 ns period; bench drives rx directly or via test_tx loopback)
//  - baud_sel=4, send 0x55 -> exactly one rx_valid, rx_data=0x55, frame_err=0, busy low after.
//  - Back-to-back 0xAA then 0xFF, zero idle gap -> two rx_valid strobes, values 0xAA, 0xFF in order.
//  - baud_sel=0: send 0x3C. Then switch to baud_sel=7 between frames and send 0xC3 -> both received.
//    Also toggle baud_sel mid-frame -> no corruption.
//  - rx low for 200 ns only (< half bit at 115200) -> no rx_valid, no frame_err, busy returns 0.
//  - 0x81 with stop bit forced 0, line held low for 3 bit-times -> frame_err once, rx_data unchanged,
//    no new frame until rx high.
//  - Assert rst during bit 4 of 0x5A -> outputs 0 immediately; next clean 0x5A received correctly.
//    With UART_RX_PARITY_EN: 0x07 with parity bit 0 -> rx_valid plus parity_err.

Source files
------------

// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared UART definitions used by the receiver (uart_rx) and the transmitter
// (test_tx):
//   - BAUD_RATE[0:7]  baud table indexed by baud_sel
//   - div_for()       ticks-per-oversample divisor, rounded to nearest
//   - rx_state_e      receiver FSM state encoding
//   - even_parity_ok  parity helper over data + parity bit
// Optional feature macro: UART_RX_PARITY_EN (adds the PARITY state).
// -----------------------------------------------------------------------------
package uart_pkg;

   localparam int DATA_BITS = 8;
   localparam int DIV_W     = 16;

   localparam int BAUD_RATE [0:7] = '{
      32'd9600,   32'd19200,  32'd38400,  32'd57600,
      32'd115200, 32'd230400, 32'd460800, 32'd921600
   };

   // Encodings stay fixed whether or not the parity state exists, so both
   // builds decode the shared states identically.
   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_START     = 3'd1,
      ST_DATA      = 3'd2,
      ST_STOP      = 3'd3,
      ST_WAIT_IDLE = 3'd4
`ifdef UART_RX_PARITY_EN
      , ST_PARITY  = 3'd5
`endif
   } rx_state_e;

   // round(clk_hz / (baud * os)); only ever evaluated on constants.
   function automatic int div_for(input int clk_hz, input logic [2:0] sel, input int os);
      int den;
      den = BAUD_RATE[sel] * os;
      return (clk_hz + (den / 32'sd2)) / den;
   endfunction

   // Even parity: the data bits plus the parity bit must XOR to zero.
   function automatic logic even_parity_ok(input logic [DATA_BITS:0] v);
      return ~(^v);
   endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// -----------------------------------------------------------------------------
// uart_baud_tick
// Free-running oversample tick generator. Counts 0..div-1 and emits a
// one-cycle tick each time the count wraps. restart forces the count back
// to 0 so the first tick lands a full period after a start edge.
// Ports:
//   clk      in   system clock
//   rst      in   asynchronous, active-high reset
//   div      in   DIV_W  clock cycles per tick (must be >= 1)
//   restart  in   synchronous restart of the phase counter
//   tick     out  one-cycle oversample strobe (registered)
// -----------------------------------------------------------------------------
module uart_baud_tick
   import uart_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic [DIV_W-1:0] div,
   input  logic             restart,
   output logic             tick
);

   logic [DIV_W-1:0] cnt_r;
   logic             tick_r;
   logic             last_s;

   // ">=" rather than "==" so a smaller div on a live counter still wraps.
   assign last_s = (cnt_r >= (div - 16'd1));

   // Phase counter and registered tick strobe.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_r  <= 16'd0;
         tick_r <= 1'b0;
      end else if (restart) begin
         cnt_r  <= 16'd0;
         tick_r <= 1'b0;
      end else if (last_s) begin
         cnt_r  <= 16'd0;
         tick_r <= 1'b1;
      end else begin
         cnt_r  <= cnt_r + 16'd1;
         tick_r <= 1'b0;
      end
   end

   assign tick = tick_r;

endmodule

// File: rtl/uart_rx.sv
// -----------------------------------------------------------------------------
// uart_rx
// 8-bit UART receiver, LSB first, 1 stop bit, 16x oversampling. Uses the same
// baud_sel table as test_tx so the two loop back directly.
// Optional feature macro: UART_RX_PARITY_EN -- adds an even-parity bit after
// the data bits; parity_err pulses with rx_valid on mismatch.
// Ports:
//   clk        in   system clock (CLK_HZ)
//   rst        in   asynchronous, active-high reset
//   baud_sel   in   3  baud index, latched at start-bit detect
//   rx         in   serial line, async to clk, idle high
//   rx_data    out  8  last good byte, held until the next good frame
//   rx_valid   out  one-cycle strobe: rx_data updated
//   frame_err  out  one-cycle strobe: stop bit sampled low
//   parity_err out  one-cycle strobe with rx_valid on parity mismatch
//   busy       out  high from start detect until the frame ends
// -----------------------------------------------------------------------------
module uart_rx
   import uart_pkg::*;
#(
   parameter int CLK_HZ     = 50_000_000,
   parameter int OVERSAMPLE = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [2:0]           baud_sel,
   input  logic                 rx,
   output logic [DATA_BITS-1:0] rx_data,
   output logic                 rx_valid,
   output logic                 frame_err,
   output logic                 parity_err,
   output logic                 busy
);

   localparam int TC_W = $clog2(OVERSAMPLE);
   localparam logic [TC_W-1:0] TC_ZERO   = TC_W'(0);
   localparam logic [TC_W-1:0] TC_ONE    = TC_W'(1);
   localparam logic [TC_W-1:0] HALF_LAST = TC_W'(OVERSAMPLE / 2 - 1);
   localparam logic [TC_W-1:0] FULL_LAST = TC_W'(OVERSAMPLE - 1);
   localparam logic [2:0]      IDX_LAST  = 3'(DATA_BITS - 1);

   localparam logic [DIV_W-1:0] DIV_TAB [0:7] = '{
      DIV_W'(div_for(CLK_HZ, 3'd0, OVERSAMPLE)), DIV_W'(div_for(CLK_HZ, 3'd1, OVERSAMPLE)),
      DIV_W'(div_for(CLK_HZ, 3'd2, OVERSAMPLE)), DIV_W'(div_for(CLK_HZ, 3'd3, OVERSAMPLE)),
      DIV_W'(div_for(CLK_HZ, 3'd4, OVERSAMPLE)), DIV_W'(div_for(CLK_HZ, 3'd5, OVERSAMPLE)),
      DIV_W'(div_for(CLK_HZ, 3'd6, OVERSAMPLE)), DIV_W'(div_for(CLK_HZ, 3'd7, OVERSAMPLE))
   };

   // Synchroniser and edge register
   logic sync1_r;
   logic rx_s;
   logic rx_d;

   // FSM and datapath
   rx_state_e            state_r,  state_nxt;
   logic [TC_W-1:0]      tcnt_r,   tcnt_nxt;
   logic [2:0]           idx_r,    idx_nxt;
   logic [DATA_BITS-1:0] shift_r,  shift_nxt;
   logic [DIV_W-1:0]     div_r,    div_nxt;
   logic                 restart_s;
   logic                 tick_s;
   logic                 valid_set_s;
   logic                 ferr_set_s;
   logic                 busy_nxt;
`ifdef UART_RX_PARITY_EN
   logic                 par_r, par_nxt;
   logic                 perr_set_s;
   logic                 parity_err_r;
`endif

   // Registered outputs
   logic [DATA_BITS-1:0] rx_data_r;
   logic                 rx_valid_r;
   logic                 frame_err_r;
   logic                 busy_r;

   uart_baud_tick u_tick (
      .clk     (clk),
      .rst     (rst),
      .div     (div_r),
      .restart (restart_s),
      .tick    (tick_s)
   );

   // Two-flop synchroniser for the async pin, then one edge-detect stage.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1_r <= 1'b1;
         rx_s    <= 1'b1;
         rx_d    <= 1'b1;
      end else begin
         sync1_r <= rx;
         rx_s    <= sync1_r;
         rx_d    <= rx_s;
      end
   end

   // FSM state and datapath registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r <= ST_IDLE;
         tcnt_r  <= TC_ZERO;
         idx_r   <= 3'd0;
         shift_r <= {DATA_BITS{1'b0}};
         div_r   <= DIV_TAB[0];
`ifdef UART_RX_PARITY_EN
         par_r   <= 1'b0;
`endif
      end else begin
         state_r <= state_nxt;
         tcnt_r  <= tcnt_nxt;
         idx_r   <= idx_nxt;
         shift_r <= shift_nxt;
         div_r   <= div_nxt;
`ifdef UART_RX_PARITY_EN
         par_r   <= par_nxt;
`endif
      end
   end

   // Next-state logic; tcnt_r counts oversample ticks within the current bit.
   always_comb begin
      state_nxt   = state_r;
      tcnt_nxt    = tcnt_r;
      idx_nxt     = idx_r;
      shift_nxt   = shift_r;
      div_nxt     = div_r;
      restart_s   = 1'b0;
      valid_set_s = 1'b0;
      ferr_set_s  = 1'b0;
`ifdef UART_RX_PARITY_EN
      par_nxt     = par_r;
      perr_set_s  = 1'b0;
`endif
      case (state_r)
         ST_IDLE: begin
            if (rx_d && !rx_s) begin
               state_nxt = ST_START;
               tcnt_nxt  = TC_ZERO;
               div_nxt   = DIV_TAB[baud_sel];
               restart_s = 1'b1;
            end else begin
               state_nxt = ST_IDLE;
            end
         end
         ST_START: begin
            // Half a bit in: still low means a real start bit, else a glitch.
            if (tick_s && (tcnt_r == HALF_LAST)) begin
               tcnt_nxt = TC_ZERO;
               if (!rx_s) begin
                  state_nxt = ST_DATA;
                  idx_nxt   = 3'd0;
               end else begin
                  state_nxt = ST_IDLE;
               end
            end else if (tick_s) begin
               tcnt_nxt = tcnt_r + TC_ONE;
            end else begin
               tcnt_nxt = tcnt_r;
            end
         end
         ST_DATA: begin
            // LSB arrives first, so shift in from the top.
            if (tick_s && (tcnt_r == FULL_LAST)) begin
               tcnt_nxt  = TC_ZERO;
               shift_nxt = {rx_s, shift_r[DATA_BITS-1:1]};
               if (idx_r == IDX_LAST) begin
`ifdef UART_RX_PARITY_EN
                  state_nxt = ST_PARITY;
`else
                  state_nxt = ST_STOP;
`endif
               end else begin
                  idx_nxt = idx_r + 3'd1;
               end
            end else if (tick_s) begin
               tcnt_nxt = tcnt_r + TC_ONE;
            end else begin
               tcnt_nxt = tcnt_r;
            end
         end
`ifdef UART_RX_PARITY_EN
         ST_PARITY: begin
            if (tick_s && (tcnt_r == FULL_LAST)) begin
               tcnt_nxt  = TC_ZERO;
               par_nxt   = rx_s;
               state_nxt = ST_STOP;
            end else if (tick_s) begin
               tcnt_nxt = tcnt_r + TC_ONE;
            end else begin
               tcnt_nxt = tcnt_r;
            end
         end
`endif
         ST_STOP: begin
            // Returning straight to IDLE mid-stop-bit lets a back-to-back
            // start edge half a bit later be caught.
            if (tick_s && (tcnt_r == FULL_LAST)) begin
               tcnt_nxt = TC_ZERO;
               if (rx_s) begin
                  state_nxt   = ST_IDLE;
                  valid_set_s = 1'b1;
`ifdef UART_RX_PARITY_EN
                  perr_set_s  = ~even_parity_ok({par_r, shift_r});
`endif
               end else begin
                  state_nxt  = ST_WAIT_IDLE;
                  ferr_set_s = 1'b1;
               end
            end else if (tick_s) begin
               tcnt_nxt = tcnt_r + TC_ONE;
            end else begin
               tcnt_nxt = tcnt_r;
            end
         end
         ST_WAIT_IDLE: begin
            // A held-low line (break) must go high before a new start is armed.
            if (rx_s) begin
               state_nxt = ST_IDLE;
            end else begin
               state_nxt = ST_WAIT_IDLE;
            end
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
      busy_nxt = (state_nxt != ST_IDLE) && (state_nxt != ST_WAIT_IDLE);
   end

   // Output registers: strobes last exactly one cycle; rx_data holds until the next good frame.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rx_data_r    <= {DATA_BITS{1'b0}};
         rx_valid_r   <= 1'b0;
         frame_err_r  <= 1'b0;
         busy_r       <= 1'b0;
`ifdef UART_RX_PARITY_EN
         parity_err_r <= 1'b0;
`endif
      end else begin
         if (valid_set_s) begin
            rx_data_r <= shift_r;
         end else begin
            rx_data_r <= rx_data_r;
         end
         rx_valid_r   <= valid_set_s;
         frame_err_r  <= ferr_set_s;
         busy_r       <= busy_nxt;
`ifdef UART_RX_PARITY_EN
         parity_err_r <= perr_set_s;
`endif
      end
   end

   assign rx_data   = rx_data_r;
   assign rx_valid  = rx_valid_r;
   assign frame_err = frame_err_r;
   assign busy      = busy_r;
`ifdef UART_RX_PARITY_EN
   assign parity_err = parity_err_r;
`else
   assign parity_err = 1'b0;
`endif

endmodule
